// File: rtl/pipe_pkg.sv
// Shared constants for the 5-stage RV64 pipeline: datapath width, ALU op codes, forwarding selects.
// Latency: n/a (constants only).
// Backpressure: n/a.
package pipe_pkg;

  localparam int XLEN = 64;
  localparam int REGW = 5;

  // ALU operation codes carried in id_ex_alu_ctrl
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  // Operand source selects; 2'b11 is unused and falls back to the register value
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/alu64.sv
// Combinational XLEN-bit ALU with zero flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
//
// Ports:
//   i_op     ALU operation code (pipe_pkg ALU_*)
//   i_a/i_b  operands A and B
//   o_result result, modulo 2^XLEN; unknown op codes give 0
//   o_zero   high when o_result == 0
module alu64 #(
  parameter int XLEN = pipe_pkg::XLEN
) (
  input  logic [3:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_result,
  output logic            o_zero
);
  import pipe_pkg::*;

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] w_shamt;
  logic           w_lt_s;
  logic           w_lt_u;

  // Shifts only honour the low log2(XLEN) bits of operand B, as RV64 does.
  assign w_shamt = i_b[SHW-1:0];
  assign w_lt_s  = $signed(i_a) < $signed(i_b);
  assign w_lt_u  = i_a < i_b;

  always_comb begin
    o_result = '0;
    case (i_op)
      ALU_AND:  o_result = i_a & i_b;
      ALU_OR:   o_result = i_a | i_b;
      ALU_ADD:  o_result = i_a + i_b;
      ALU_SUB:  o_result = i_a - i_b;
      ALU_XOR:  o_result = i_a ^ i_b;
      ALU_SLL:  o_result = i_a << w_shamt;
      ALU_SRL:  o_result = i_a >> w_shamt;
      ALU_SRA:  o_result = XLEN'($signed(i_a) >>> w_shamt);
      ALU_SLT:  o_result = {{(XLEN-1){1'b0}}, w_lt_s};
      ALU_SLTU: o_result = {{(XLEN-1){1'b0}}, w_lt_u};
      default:  o_result = '0;
    endcase
  end

  assign o_zero = (o_result == '0);

endmodule

// File: rtl/ex_stage_fwd_alu.sv
// Execute stage: operand forwarding from EX/MEM and MEM/WB, ALU, branch target, EX/MEM register.
// Latency: 1 cycle from ID/EX inputs to ex_mem_* outputs; forward_a/forward_b are combinational.
// Backpressure: none; the EX/MEM register loads every cycle, flush turns the slot into a bubble.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-low reset
//   id_ex_*               ID/EX register contents for the instruction in EX
//   flush                 clears the control bits captured at the next edge
//   mem_wb_*              write-back value/destination/enable for the MEM/WB forward path
//   ex_mem_*              registered results, destination and control bits
//   forward_a/forward_b   operand source selects (debug visibility)
module ex_stage_fwd_alu #(
  parameter int XLEN = pipe_pkg::XLEN,
  parameter int REGW = pipe_pkg::REGW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] id_ex_pc,
  input  logic [XLEN-1:0] id_ex_rd1,
  input  logic [XLEN-1:0] id_ex_rd2,
  input  logic [XLEN-1:0] id_ex_imm,
  input  logic [REGW-1:0] id_ex_rs1,
  input  logic [REGW-1:0] id_ex_rs2,
  input  logic [REGW-1:0] id_ex_rd,
  input  logic [3:0]      id_ex_alu_ctrl,
  input  logic            id_ex_alusrc,
  input  logic            id_ex_branch,
  input  logic            id_ex_memread,
  input  logic            id_ex_memwrite,
  input  logic            id_ex_memtoreg,
  input  logic            id_ex_regwrite,
  input  logic            flush,
  input  logic [XLEN-1:0] mem_wb_data,
  input  logic [REGW-1:0] mem_wb_rd,
  input  logic            mem_wb_regwrite,
  output logic [XLEN-1:0] ex_mem_alu_result,
  output logic [XLEN-1:0] ex_mem_store_data,
  output logic [XLEN-1:0] ex_mem_pc,
  output logic            ex_mem_zero,
  output logic [REGW-1:0] ex_mem_rd,
  output logic            ex_mem_branch,
  output logic            ex_mem_memread,
  output logic            ex_mem_memwrite,
  output logic            ex_mem_memtoreg,
  output logic            ex_mem_regwrite,
  output logic [1:0]      forward_a,
  output logic [1:0]      forward_b
);
  import pipe_pkg::*;

  // EX/MEM pipeline register
  logic [XLEN-1:0] r_alu_result;
  logic [XLEN-1:0] r_store_data;
  logic [XLEN-1:0] r_pc;
  logic            r_zero;
  logic [REGW-1:0] r_rd;
  logic            r_branch;
  logic            r_memread;
  logic            r_memwrite;
  logic            r_memtoreg;
  logic            r_regwrite;

  logic [1:0]      w_fwd_a;
  logic [1:0]      w_fwd_b;
  logic [XLEN-1:0] w_op_a;
  logic [XLEN-1:0] w_fwd_rs2;
  logic [XLEN-1:0] w_op_b;
  logic [XLEN-1:0] w_alu_result;
  logic            w_alu_zero;
  logic [XLEN-1:0] w_br_target;

  // Younger producer (EX/MEM) is checked first so it wins over MEM/WB.
  // x0 is hard-wired zero and must never forward; a flushed slot has
  // regwrite cleared and so never matches either.
  always_comb begin
    w_fwd_a = FWD_REG;
    if (r_regwrite && (r_rd != '0) && (r_rd == id_ex_rs1))
      w_fwd_a = FWD_MEM;
    else if (mem_wb_regwrite && (mem_wb_rd != '0) && (mem_wb_rd == id_ex_rs1))
      w_fwd_a = FWD_WB;
  end

  always_comb begin
    w_fwd_b = FWD_REG;
    if (r_regwrite && (r_rd != '0) && (r_rd == id_ex_rs2))
      w_fwd_b = FWD_MEM;
    else if (mem_wb_regwrite && (mem_wb_rd != '0) && (mem_wb_rd == id_ex_rs2))
      w_fwd_b = FWD_WB;
  end

  always_comb begin
    w_op_a = id_ex_rd1;
    case (w_fwd_a)
      FWD_WB:  w_op_a = mem_wb_data;
      FWD_MEM: w_op_a = r_alu_result;
      default: w_op_a = id_ex_rd1;
    endcase
  end

  always_comb begin
    w_fwd_rs2 = id_ex_rd2;
    case (w_fwd_b)
      FWD_WB:  w_fwd_rs2 = mem_wb_data;
      FWD_MEM: w_fwd_rs2 = r_alu_result;
      default: w_fwd_rs2 = id_ex_rd2;
    endcase
  end

  // Forwarded rs2 feeds the store data even when B takes the immediate.
  assign w_op_b      = id_ex_alusrc ? id_ex_imm : w_fwd_rs2;
  assign w_br_target = id_ex_pc + (id_ex_imm << 1);

  alu64 #(.XLEN(XLEN)) u_alu (
    .i_op     (id_ex_alu_ctrl),
    .i_a      (w_op_a),
    .i_b      (w_op_b),
    .o_result (w_alu_result),
    .o_zero   (w_alu_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_alu_result <= '0;
      r_store_data <= '0;
      r_pc         <= '0;
      r_zero       <= 1'b0;
      r_rd         <= '0;
      r_branch     <= 1'b0;
      r_memread    <= 1'b0;
      r_memwrite   <= 1'b0;
      r_memtoreg   <= 1'b0;
      r_regwrite   <= 1'b0;
    end else begin
      r_alu_result <= w_alu_result;
      r_store_data <= w_fwd_rs2;
      r_pc         <= w_br_target;
      r_zero       <= w_alu_zero;
      r_rd         <= id_ex_rd;
      r_branch     <= id_ex_branch   & ~flush;
      r_memread    <= id_ex_memread  & ~flush;
      r_memwrite   <= id_ex_memwrite & ~flush;
      r_memtoreg   <= id_ex_memtoreg & ~flush;
      r_regwrite   <= id_ex_regwrite & ~flush;
    end
  end

  assign ex_mem_alu_result = r_alu_result;
  assign ex_mem_store_data = r_store_data;
  assign ex_mem_pc         = r_pc;
  assign ex_mem_zero       = r_zero;
  assign ex_mem_rd         = r_rd;
  assign ex_mem_branch     = r_branch;
  assign ex_mem_memread    = r_memread;
  assign ex_mem_memwrite   = r_memwrite;
  assign ex_mem_memtoreg   = r_memtoreg;
  assign ex_mem_regwrite   = r_regwrite;
  assign forward_a         = w_fwd_a;
  assign forward_b         = w_fwd_b;

endmodule

// File: tb/tb_ex_stage_fwd_alu.sv
// Testbench for ex_stage_fwd_alu: directed vector table, hand sequences, randomized run vs reference model.
// Latency: checks registered outputs 1 ns after each rising edge, forwarding selects mid-cycle.
// Backpressure: n/a.
module tb_ex_stage_fwd_alu;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] id_ex_pc, id_ex_rd1, id_ex_rd2, id_ex_imm, mem_wb_data;
  logic [4:0]  id_ex_rs1, id_ex_rs2, id_ex_rd, mem_wb_rd;
  logic [3:0]  id_ex_alu_ctrl;
  logic        id_ex_alusrc, id_ex_branch, id_ex_memread, id_ex_memwrite;
  logic        id_ex_memtoreg, id_ex_regwrite, flush, mem_wb_regwrite;
  logic [63:0] ex_mem_alu_result, ex_mem_store_data, ex_mem_pc;
  logic        ex_mem_zero, ex_mem_branch, ex_mem_memread, ex_mem_memwrite;
  logic        ex_mem_memtoreg, ex_mem_regwrite;
  logic [4:0]  ex_mem_rd;
  logic [1:0]  forward_a, forward_b;

  ex_stage_fwd_alu dut (
    .clk(clk), .rst(rst),
    .id_ex_pc(id_ex_pc), .id_ex_rd1(id_ex_rd1), .id_ex_rd2(id_ex_rd2), .id_ex_imm(id_ex_imm),
    .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
    .id_ex_alu_ctrl(id_ex_alu_ctrl), .id_ex_alusrc(id_ex_alusrc),
    .id_ex_branch(id_ex_branch), .id_ex_memread(id_ex_memread), .id_ex_memwrite(id_ex_memwrite),
    .id_ex_memtoreg(id_ex_memtoreg), .id_ex_regwrite(id_ex_regwrite),
    .flush(flush), .mem_wb_data(mem_wb_data), .mem_wb_rd(mem_wb_rd), .mem_wb_regwrite(mem_wb_regwrite),
    .ex_mem_alu_result(ex_mem_alu_result), .ex_mem_store_data(ex_mem_store_data),
    .ex_mem_pc(ex_mem_pc), .ex_mem_zero(ex_mem_zero), .ex_mem_rd(ex_mem_rd),
    .ex_mem_branch(ex_mem_branch), .ex_mem_memread(ex_mem_memread), .ex_mem_memwrite(ex_mem_memwrite),
    .ex_mem_memtoreg(ex_mem_memtoreg), .ex_mem_regwrite(ex_mem_regwrite),
    .forward_a(forward_a), .forward_b(forward_b)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference view of what the EX/MEM register should hold.
  // m_ctl = {branch, memread, memwrite, memtoreg, regwrite}
  logic [63:0] m_res, m_st, m_pc;
  logic        m_zero;
  logic [4:0]  m_rd;
  logic [4:0]  m_ctl;
  logic [1:0]  s_fa, s_fb;

  typedef struct {
    logic [3:0]  op;
    logic [63:0] rd1, rd2, imm;
    logic        asrc;
    logic [63:0] exp_res;
    logic        exp_zero;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] alu_ref(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    longint sa, sb;
    int     sh;
    sa = $signed(a);
    sb = $signed(b);
    sh = int'(b & 64'd63);
    case (op)
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_XOR:  return a ^ b;
      ALU_SLL:  return a << sh;
      ALU_SRL:  return a >> sh;
      ALU_SRA:  return 64'(sa >>> sh);
      ALU_SLT:  return (sa < sb) ? 64'd1 : 64'd0;
      ALU_SLTU: return (a < b) ? 64'd1 : 64'd0;
      default:  return 64'd0;
    endcase
  endfunction

  // Value a source register really holds: the most recent in-flight writer wins.
  function automatic logic [63:0] opnd(input logic [4:0] rs, input logic [63:0] rf);
    if (rs == 5'd0) return rf;
    if (m_ctl[0] && m_rd == rs) return m_res;
    if (mem_wb_regwrite && mem_wb_rd == rs) return mem_wb_data;
    return rf;
  endfunction

  function automatic logic [1:0] fsel(input logic [4:0] rs);
    if (rs == 5'd0) return 2'b00;
    if (m_ctl[0] && m_rd == rs) return 2'b10;
    if (mem_wb_regwrite && mem_wb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_res = '0; m_st = '0; m_pc = '0; m_zero = 1'b0; m_rd = '0; m_ctl = '0;
  endtask

  task automatic instr(input logic [3:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [63:0] v1, input logic [63:0] v2,
                       input logic [63:0] imm, input logic asrc, input logic [4:0] ctl,
                       input logic fl, input logic [63:0] pc);
    @(negedge clk);
    id_ex_alu_ctrl = op; id_ex_rs1 = rs1; id_ex_rs2 = rs2; id_ex_rd = rd;
    id_ex_rd1 = v1; id_ex_rd2 = v2; id_ex_imm = imm; id_ex_alusrc = asrc;
    {id_ex_branch, id_ex_memread, id_ex_memwrite, id_ex_memtoreg, id_ex_regwrite} = ctl;
    flush = fl; id_ex_pc = pc;
  endtask

  task automatic wb(input logic rw, input logic [4:0] rd, input logic [63:0] d);
    mem_wb_regwrite = rw; mem_wb_rd = rd; mem_wb_data = d;
  endtask

  // Check selects mid-cycle, then clock once and check the register against the model.
  task automatic step(input string tag);
    logic [63:0] a, b, ob, r;
    #1;
    s_fa = forward_a;
    s_fb = forward_b;
    chk({tag, " forward_a"}, s_fa, fsel(id_ex_rs1));
    chk({tag, " forward_b"}, s_fb, fsel(id_ex_rs2));
    a  = opnd(id_ex_rs1, id_ex_rd1);
    b  = opnd(id_ex_rs2, id_ex_rd2);
    ob = id_ex_alusrc ? id_ex_imm : b;
    r  = alu_ref(id_ex_alu_ctrl, a, ob);
    @(posedge clk);
    m_res = r; m_st = b; m_pc = id_ex_pc + id_ex_imm * 2; m_zero = (r == 64'd0); m_rd = id_ex_rd;
    m_ctl = flush ? 5'd0 : {id_ex_branch, id_ex_memread, id_ex_memwrite, id_ex_memtoreg, id_ex_regwrite};
    #1;
    chk({tag, " alu_result"}, ex_mem_alu_result, m_res);
    chk({tag, " store_data"}, ex_mem_store_data, m_st);
    chk({tag, " pc"}, ex_mem_pc, m_pc);
    chk({tag, " zero"}, ex_mem_zero, m_zero);
    chk({tag, " rd"}, ex_mem_rd, m_rd);
    chk({tag, " ctl"}, {ex_mem_branch, ex_mem_memread, ex_mem_memwrite, ex_mem_memtoreg, ex_mem_regwrite}, m_ctl);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " alu_result"}, ex_mem_alu_result, 64'd0);
    chk({tag, " store_data"}, ex_mem_store_data, 64'd0);
    chk({tag, " pc"}, ex_mem_pc, 64'd0);
    chk({tag, " zero/rd"}, {ex_mem_zero, ex_mem_rd}, 64'd0);
    chk({tag, " ctl"}, {ex_mem_branch, ex_mem_memread, ex_mem_memwrite, ex_mem_memtoreg, ex_mem_regwrite}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{ALU_AND,  64'hF0, 64'h0F, 64'd0, 1'b0, 64'h00, 1'b1};
    tbl[1]  = '{ALU_OR,   64'hF0, 64'h0F, 64'd0, 1'b0, 64'hFF, 1'b0};
    tbl[2]  = '{ALU_ADD,  64'hF0, 64'h0F, 64'd0, 1'b0, 64'hFF, 1'b0};
    tbl[3]  = '{ALU_SUB,  64'hF0, 64'h0F, 64'd0, 1'b0, 64'hE1, 1'b0};
    tbl[4]  = '{ALU_SUB,  64'd5,  64'd5,  64'd0, 1'b0, 64'd0,  1'b1};
    tbl[5]  = '{ALU_SLT,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, 64'd1, 1'b0};
    tbl[6]  = '{ALU_SLTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, 64'd0, 1'b1};
    tbl[7]  = '{ALU_SLL,  64'd1,  64'd0,  64'd3, 1'b1, 64'd8,  1'b0};
    tbl[8]  = '{ALU_SRA,  64'hFFFF_FFFF_FFFF_FFF0, 64'd2, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
    tbl[9]  = '{ALU_SRL,  64'h8000_0000_0000_0000, 64'd67, 64'd0, 1'b0, 64'h1000_0000_0000_0000, 1'b0};
    tbl[10] = '{ALU_XOR,  64'hFF, 64'h0F, 64'd0, 1'b0, 64'hF0, 1'b0};
    tbl[11] = '{4'b1111,  64'h12, 64'h34, 64'd0, 1'b0, 64'd0,  1'b1};

    rst = 1'b0;
    id_ex_pc = '0; id_ex_rd1 = '0; id_ex_rd2 = '0; id_ex_imm = '0;
    id_ex_rs1 = '0; id_ex_rs2 = '0; id_ex_rd = '0; id_ex_alu_ctrl = '0; id_ex_alusrc = 1'b0;
    {id_ex_branch, id_ex_memread, id_ex_memwrite, id_ex_memtoreg, id_ex_regwrite} = '0;
    flush = 1'b0; wb(1'b0, 5'd0, 64'd0);
    model_reset();
    #3;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // ALU sweep without hazards
    for (int i = 0; i < 12; i++) begin
      instr(tbl[i].op, 5'd1, 5'd2, 5'd3, tbl[i].rd1, tbl[i].rd2, tbl[i].imm, tbl[i].asrc,
            5'b00000, 1'b0, 64'h40);
      wb(1'b0, 5'd0, 64'd0);
      step($sformatf("vec%0d", i));
      chk($sformatf("vec%0d table result", i), ex_mem_alu_result, tbl[i].exp_res);
      chk($sformatf("vec%0d table zero", i), ex_mem_zero, tbl[i].exp_zero);
    end

    // EX/MEM forwarding: add x5 = 7, then use x5
    instr(ALU_ADD, 5'd1, 5'd2, 5'd5, 64'd3, 64'd4, 64'd0, 1'b0, 5'b00001, 1'b0, 64'h0);
    step("fwd producer");
    instr(ALU_ADD, 5'd5, 5'd0, 5'd8, 64'd0, 64'd1, 64'd0, 1'b0, 5'b00001, 1'b0, 64'h0);
    step("fwd consumer");
    chk("fwd ex_mem sel", s_fa, 2'b10);
    chk("fwd ex_mem result", ex_mem_alu_result, 64'd8);
    // x0 destination must not forward
    instr(ALU_ADD, 5'd1, 5'd2, 5'd0, 64'd2, 64'd3, 64'd0, 1'b0, 5'b00001, 1'b0, 64'h0);
    step("x0 producer");
    instr(ALU_ADD, 5'd0, 5'd2, 5'd9, 64'd0, 64'd1, 64'd0, 1'b0, 5'b00001, 1'b0, 64'h0);
    step("x0 consumer");
    chk("x0 sel", s_fa, 2'b00);
    chk("x0 result", ex_mem_alu_result, 64'd1);
    // MEM/WB only
    instr(ALU_OR, 5'd7, 5'd3, 5'd10, 64'd0, 64'd0, 64'd0, 1'b0, 5'b00000, 1'b0, 64'h0);
    wb(1'b1, 5'd7, 64'h55);
    step("wb fwd");
    chk("wb sel", s_fa, 2'b01);
    chk("wb result", ex_mem_alu_result, 64'h55);
    wb(1'b0, 5'd0, 64'd0);

    // Double hazard on x6: EX/MEM holds 9, MEM/WB holds 3
    instr(ALU_ADD, 5'd1, 5'd2, 5'd6, 64'd4, 64'd5, 64'd0, 1'b0, 5'b00001, 1'b0, 64'h0);
    step("dbl producer");
    instr(ALU_OR, 5'd0, 5'd6, 5'd6, 64'd0, 64'd0, 64'd0, 1'b0, 5'b00001, 1'b0, 64'h0);
    wb(1'b1, 5'd6, 64'd3);
    step("dbl reg");
    chk("dbl sel", s_fb, 2'b10);
    chk("dbl store", ex_mem_store_data, 64'd9);
    chk("dbl result", ex_mem_alu_result, 64'd9);
    instr(ALU_ADD, 5'd0, 5'd6, 5'd11, 64'd0, 64'd0, 64'h20, 1'b1, 5'b00100, 1'b0, 64'h0);
    step("dbl imm");
    chk("dbl imm sel", s_fb, 2'b10);
    chk("dbl imm result", ex_mem_alu_result, 64'h20);
    chk("dbl imm store", ex_mem_store_data, 64'd9);
    wb(1'b0, 5'd0, 64'd0);

    // Branch target, then flush of the same instruction
    instr(ALU_ADD, 5'd1, 5'd2, 5'd12, 64'd1, 64'd2, 64'd4, 1'b0, 5'b11111, 1'b0, 64'h100);
    step("branch");
    chk("branch target", ex_mem_pc, 64'h108);
    instr(ALU_ADD, 5'd1, 5'd2, 5'd12, 64'd1, 64'd2, 64'd4, 1'b0, 5'b11111, 1'b1, 64'h100);
    step("flush");
    chk("flush ctl", {ex_mem_branch, ex_mem_memread, ex_mem_memwrite, ex_mem_memtoreg, ex_mem_regwrite}, 64'd0);
    chk("flush result", ex_mem_alu_result, 64'd3);
    instr(ALU_ADD, 5'd12, 5'd0, 5'd13, 64'h77, 64'd0, 64'd0, 1'b0, 5'b00001, 1'b0, 64'h0);
    step("bubble");
    chk("bubble sel", s_fa, 2'b00);

    // Randomized run against the reference model
    for (int n = 0; n < 400; n++) begin
      instr(4'($urandom_range(0, 15)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)),
            ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 8)) : {$urandom, $urandom},
            ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 8)) : {$urandom, $urandom},
            {$urandom, $urandom}, 1'($urandom_range(0, 1)), 5'($urandom),
            ($urandom_range(0, 7) == 0), {$urandom, $urandom});
      wb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), {$urandom, $urandom});
      step("rand");
    end

    // Mid-cycle reset discards the in-flight instruction
    wb(1'b0, 5'd0, 64'd0);
    instr(ALU_ADD, 5'd1, 5'd2, 5'd14, 64'd10, 64'd20, 64'd8, 1'b0, 5'b11111, 1'b0, 64'h200);
    step("pre reset");
    instr(ALU_OR, 5'd1, 5'd2, 5'd15, 64'h5, 64'hA, 64'd1, 1'b0, 5'b11111, 1'b0, 64'h300);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    chk_all_zero("async reset");
    @(posedge clk);
    #1;
    chk_all_zero("reset held");
    @(negedge clk);
    rst = 1'b1;
    instr(ALU_ADD, 5'd1, 5'd2, 5'd3, 64'd1, 64'd1, 64'd0, 1'b0, 5'b00001, 1'b0, 64'h0);
    step("post reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
